// File: rtl/text_line_scheduler_if.sv
// Text RAM read port and character renderer handshake between the line
// scheduler (master) and the RAM/renderer side (slave).
interface text_line_scheduler_if #(
   parameter int CHAR_W = 8,
   parameter int X_W    = 10,
   parameter int Y_W    = 9,
   parameter int SIZE_W = 4,
   parameter int LEN_W  = 6
) ();
   logic              mem_rd;
   logic [LEN_W-1:0]  mem_addr;
   logic [CHAR_W-1:0] mem_data;
   logic [CHAR_W-1:0] rend_char;
   logic [X_W-1:0]    rend_x;
   logic [Y_W-1:0]    rend_y;
   logic [SIZE_W-1:0] rend_size;
   logic              rend_enable;
   logic              rend_finished;

   modport master (
      output mem_rd, mem_addr, rend_char, rend_x, rend_y, rend_size, rend_enable,
      input  mem_data, rend_finished
   );

   modport slave (
      input  mem_rd, mem_addr, rend_char, rend_x, rend_y, rend_size, rend_enable,
      output mem_data, rend_finished
   );
endinterface

// File: rtl/text_line_scheduler.sv
// Walks a string in the text RAM, places each glyph on screen and drives the
// character renderer one glyph at a time, handling space, newline, wrap and clip.
module text_line_scheduler #(
   parameter int CHAR_W      = 8,
   parameter int X_W         = 10,
   parameter int Y_W         = 9,
   parameter int SIZE_W      = 4,
   parameter int LEN_W       = 6,
   parameter int FONT_WIDTH  = 5,
   parameter int FONT_HEIGHT = 7
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               start,
   input  logic [LEN_W-1:0]   text_length,
   input  logic [X_W-1:0]     origin_x,
   input  logic [Y_W-1:0]     origin_y,
   input  logic [SIZE_W-1:0]  size,
   input  logic [X_W-1:0]     limit_x,
   input  logic [Y_W-1:0]     limit_y,
   output logic               busy,
   output logic               done,
   output logic               clipped,
   text_line_scheduler_if.master bus
);

   localparam logic [CHAR_W-1:0] CH_NEWLINE = CHAR_W'(8'h0A);
   localparam logic [CHAR_W-1:0] CH_SPACE   = CHAR_W'(8'h20);
   localparam logic [X_W-1:0]    ADV_UNIT   = X_W'(FONT_WIDTH + 1);
   localparam logic [Y_W-1:0]    STEP_UNIT  = Y_W'(FONT_HEIGHT + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_WAIT, S_CLASSIFY, S_SETUP,
      S_RUN, S_ADVANCE, S_NEXT, S_FINISH
   } state_t;

   state_t state, state_nxt;

   logic [LEN_W-1:0]  idx, len_r;
   logic [X_W-1:0]    ox_r, cx, lim_x_r, adv;
   logic [Y_W-1:0]    oy_r, cy, lim_y_r, step;
   logic [SIZE_W-1:0] size_r;
   logic [CHAR_W-1:0] ch;

   logic [LEN_W-1:0]  idx_inc;
   logic [X_W:0]      cx_end;
   logic [Y_W:0]      cy_end;
   logic              wrap_hit, clip_hit;

   // One spare bit on the end positions keeps a far-right or far-down cursor
   // from wrapping around and passing the margin test.
   assign idx_inc  = idx + LEN_W'(1);
   assign cx_end   = {1'b0, cx} + {1'b0, adv};
   assign cy_end   = {1'b0, cy} + {1'b0, step};
   assign wrap_hit = (cx_end > {1'b0, lim_x_r}) && (cx != ox_r);
   assign clip_hit = cy_end > {1'b0, lim_y_r};

   assign bus.mem_addr  = idx;
   assign bus.rend_char = ch;
   assign bus.rend_x    = cx;
   assign bus.rend_y    = cy;
   assign bus.rend_size = size_r;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state <= S_IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      bus.mem_rd      = 1'b0;
      bus.rend_enable = 1'b0;
      busy            = 1'b1;
      done            = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = (text_length == '0) ? S_FINISH : S_FETCH;
         end
         S_FETCH: begin
            bus.mem_rd = 1'b1;
            state_nxt  = S_WAIT;
         end
         S_WAIT: state_nxt = S_CLASSIFY;
         S_CLASSIFY: begin
            // A wrap stays here so the same code is re-judged on the new line.
            if (ch == CH_NEWLINE)    state_nxt = S_NEXT;
            else if (wrap_hit)       state_nxt = S_CLASSIFY;
            else if (clip_hit)       state_nxt = S_FINISH;
            else if (ch == CH_SPACE) state_nxt = S_NEXT;
            else                     state_nxt = S_SETUP;
         end
         S_SETUP: if (!bus.rend_finished) state_nxt = S_RUN;
         S_RUN: begin
            bus.rend_enable = 1'b1;
            if (bus.rend_finished) state_nxt = S_ADVANCE;
         end
         S_ADVANCE: state_nxt = S_NEXT;
         S_NEXT:    state_nxt = (idx_inc == len_r) ? S_FINISH : S_FETCH;
         S_FINISH: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         idx     <= '0;
         len_r   <= '0;
         ox_r    <= '0;
         oy_r    <= '0;
         cx      <= '0;
         cy      <= '0;
         lim_x_r <= '0;
         lim_y_r <= '0;
         adv     <= '0;
         step    <= '0;
         size_r  <= '0;
         ch      <= '0;
         clipped <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               len_r   <= text_length;
               ox_r    <= origin_x;
               oy_r    <= origin_y;
               cx      <= origin_x;
               cy      <= origin_y;
               lim_x_r <= limit_x;
               lim_y_r <= limit_y;
               size_r  <= size;
               adv     <= X_W'(size) * ADV_UNIT;
               step    <= Y_W'(size) * STEP_UNIT;
               idx     <= '0;
               clipped <= 1'b0;
            end
            S_WAIT: ch <= bus.mem_data;
            S_CLASSIFY: begin
               if (ch == CH_NEWLINE || wrap_hit) begin
                  cx <= ox_r;
                  cy <= cy + step;
               end else if (clip_hit) begin
                  clipped <= 1'b1;
               end else if (ch == CH_SPACE) begin
                  cx <= cx + adv;
               end
            end
            S_ADVANCE: cx  <= cx + adv;
            S_NEXT:    idx <= idx_inc;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_text_line_scheduler.sv
// Randomized and directed stimulus for text_line_scheduler, checked by a
// scoreboard fed from a line-layout reference model.
module tb_text_line_scheduler;

   localparam int CHAR_W = 8, X_W = 10, Y_W = 9, SIZE_W = 4, LEN_W = 6;

   logic              clock = 1'b0;
   logic              resetn;
   logic              start;
   logic [LEN_W-1:0]  text_length;
   logic [X_W-1:0]    origin_x, limit_x;
   logic [Y_W-1:0]    origin_y, limit_y;
   logic [SIZE_W-1:0] size;
   logic              busy, done, clipped;

   text_line_scheduler_if #(.CHAR_W(CHAR_W), .X_W(X_W), .Y_W(Y_W),
                            .SIZE_W(SIZE_W), .LEN_W(LEN_W)) bus ();

   text_line_scheduler dut (
      .clock       (clock),
      .resetn      (resetn),
      .start       (start),
      .text_length (text_length),
      .origin_x    (origin_x),
      .origin_y    (origin_y),
      .size        (size),
      .limit_x     (limit_x),
      .limit_y     (limit_y),
      .busy        (busy),
      .done        (done),
      .clipped     (clipped),
      .bus         (bus)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s", name);
   endtask

   // Text RAM: one-cycle read latency
   logic [7:0] ram [64];
   always @(posedge clock)
      if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];

   // Renderer: finishes after a random delay, keeps finished high a little
   // while after being disabled.
   int r_cnt, r_hold;
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bus.rend_finished <= 1'b0;
         r_cnt  <= 0;
         r_hold <= 0;
      end else if (bus.rend_enable) begin
         if (r_cnt == 0) bus.rend_finished <= 1'b1;
         else            r_cnt <= r_cnt - 1;
         r_hold <= $urandom_range(0, 3);
      end else begin
         if (r_hold != 0) r_hold <= r_hold - 1;
         else             bus.rend_finished <= 1'b0;
         r_cnt <= $urandom_range(0, 5);
      end
   end

   // Reference model: lay out ram[0..len-1] as text lines
   logic [30:0] exp_glyph [$];
   logic        exp_clip  [$];
   logic        last_clip;

   task automatic model_job(input int len, input int ox, input int oy, input int sz,
                            input int lx, input int ly, output int fetches);
      int adv, step, cx, cy, c;
      bit clip;
      adv = (sz * 6) % 1024;
      step = (sz * 8) % 512;
      cx = ox;
      cy = oy;
      clip = 0;
      fetches = 0;
      for (int i = 0; i < len; i++) begin
         c = ram[i];
         fetches++;
         if (c == 10) begin
            cx = ox;
            cy = (cy + step) % 512;
            continue;
         end
         if (cx + adv > lx && cx != ox) begin
            cx = ox;
            cy = (cy + step) % 512;
         end
         if (cy + step > ly) begin
            clip = 1;
            break;
         end
         if (c != 32) exp_glyph.push_back({c[7:0], cx[9:0], cy[8:0], sz[3:0]});
         cx = (cx + adv) % 1024;
      end
      exp_clip.push_back(clip);
      last_clip = clip;
   endtask

   // Monitor / scoreboard
   logic        prev_en = 1'b0, prev_done = 1'b0;
   logic [30:0] cur, run_cap;
   int          job_mem_rd = 0;
   int          jobs_done = 0;

   always @(negedge clock) begin
      if (!resetn) begin
         prev_en   = 1'b0;
         prev_done = 1'b0;
      end else begin
         cur = {bus.rend_char, bus.rend_x, bus.rend_y, bus.rend_size};
         if (bus.rend_enable && !prev_en) begin
            if (exp_glyph.size() == 0) fail_now("glyph_unexpected");
            else check("glyph", {1'b0, cur}, {1'b0, exp_glyph.pop_front()});
            run_cap = cur;
         end else if (bus.rend_enable) begin
            check("rend_stable", {1'b0, cur}, {1'b0, run_cap});
         end
         if (bus.mem_rd) job_mem_rd++;
         if (prev_done) check("busy_after_done", {31'b0, busy}, 32'd0);
         if (done) begin
            check("busy_in_done", {31'b0, busy}, 32'd1);
            if (exp_clip.size() == 0) fail_now("done_unexpected");
            else check("clipped", {31'b0, clipped}, {31'b0, exp_clip.pop_front()});
            check("glyphs_left", exp_glyph.size(), 32'd0);
            jobs_done++;
         end
         prev_en   = bus.rend_enable;
         prev_done = done;
      end
   end

   task automatic scramble_inputs();
      text_length = LEN_W'($urandom);
      origin_x    = X_W'($urandom);
      origin_y    = Y_W'($urandom);
      size        = SIZE_W'($urandom);
      limit_x     = X_W'($urandom);
      limit_y     = Y_W'($urandom);
   endtask

   task automatic run_job(input int len, input int ox, input int oy, input int sz,
                          input int lx, input int ly, input bit mid_pulse);
      int fetches, start_jobs, cyc;
      model_job(len, ox, oy, sz, lx, ly, fetches);
      start_jobs = jobs_done;
      @(negedge clock);
      job_mem_rd  = 0;
      start       = 1'b1;
      text_length = LEN_W'(len);
      origin_x    = X_W'(ox);
      origin_y    = Y_W'(oy);
      size        = SIZE_W'(sz);
      limit_x     = X_W'(lx);
      limit_y     = Y_W'(ly);
      @(negedge clock);
      start = 1'b0;
      scramble_inputs();
      check("busy_after_start", {31'b0, busy}, 32'd1);
      if (len == 0) check("done_len0", {31'b0, done}, 32'd1);
      else          check("fetch_first", {31'b0, bus.mem_rd}, 32'd1);
      cyc = 0;
      while (jobs_done == start_jobs && cyc < 5000) begin
         @(negedge clock);
         cyc++;
         if (mid_pulse && cyc == 6) begin
            start       = 1'b1;
            text_length = LEN_W'(3);
            origin_x    = X_W'(300);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (cyc >= 5000) fail_now("job_timeout");
      check("fetch_count", job_mem_rd, fetches);
      @(negedge clock);
      @(negedge clock);
   endtask

   task automatic run_text(input string s, input int ox, input int oy, input int sz,
                           input int lx, input int ly, input bit mid_pulse);
      for (int i = 0; i < s.len(); i++) ram[i] = s[i];
      run_job(s.len(), ox, oy, sz, lx, ly, mid_pulse);
   endtask

   task automatic run_random();
      int len, r, sz, ox, oy;
      len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) begin
         r = $urandom_range(0, 9);
         if (r == 0)      ram[i] = 8'h0A;
         else if (r == 1) ram[i] = 8'h20;
         else             ram[i] = 8'(65 + $urandom_range(0, 25));
      end
      sz = $urandom_range(1, 4);
      ox = $urandom_range(0, 150);
      oy = $urandom_range(0, 80);
      run_job(len, ox, oy, sz, ox + $urandom_range(0, 120), oy + $urandom_range(0, 200), 1'b0);
   endtask

   task automatic reset_mid_run();
      int cyc;
      for (int i = 0; i < 4; i++) ram[i] = 8'(65 + i);
      begin : launch
         int f;
         model_job(4, 5, 5, 1, 640, 480, f);
      end
      @(negedge clock);
      start       = 1'b1;
      text_length = LEN_W'(4);
      origin_x    = X_W'(5);
      origin_y    = Y_W'(5);
      size        = SIZE_W'(1);
      limit_x     = X_W'(640);
      limit_y     = Y_W'(480);
      @(negedge clock);
      start = 1'b0;
      cyc = 0;
      while (!bus.rend_enable && cyc < 200) begin
         @(negedge clock);
         cyc++;
      end
      if (cyc >= 200) fail_now("wait_enable_timeout");
      #2 resetn = 1'b0;
      #1;
      check("rst_rend_enable", {31'b0, bus.rend_enable}, 32'd0);
      check("rst_busy",        {31'b0, busy}, 32'd0);
      check("rst_done",        {31'b0, done}, 32'd0);
      check("rst_clipped",     {31'b0, clipped}, 32'd0);
      check("rst_mem_rd",      {31'b0, bus.mem_rd}, 32'd0);
      check("rst_mem_addr",    {26'b0, bus.mem_addr}, 32'd0);
      check("rst_rend_bus",    {1'b0, bus.rend_char, bus.rend_x, bus.rend_y, bus.rend_size}, 32'd0);
      exp_glyph.delete();
      exp_clip.delete();
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      text_length = '0;
      origin_x = '0;
      origin_y = '0;
      size     = '0;
      limit_x  = '0;
      limit_y  = '0;
      for (int i = 0; i < 64; i++) ram[i] = 8'h00;
      repeat (3) @(negedge clock);
      check("reset_busy",    {31'b0, busy}, 32'd0);
      check("reset_done",    {31'b0, done}, 32'd0);
      check("reset_clipped", {31'b0, clipped}, 32'd0);
      check("reset_mem_rd",  {31'b0, bus.mem_rd}, 32'd0);
      check("reset_enable",  {31'b0, bus.rend_enable}, 32'd0);
      check("reset_rend",    {1'b0, bus.rend_char, bus.rend_x, bus.rend_y, bus.rend_size}, 32'd0);
      resetn = 1'b1;
      @(negedge clock);

      run_text("",        0,  0, 1,  640, 480, 1'b0);
      run_text("AB",      10, 20, 2, 640, 480, 1'b0);
      run_text("A\nB",    0,  0, 1,  640, 480, 1'b0);
      run_text("ABC",     0,  0, 1,  15,  480, 1'b0);
      run_text("A\nB\nC", 0,  0, 2,  640, 20,  1'b0);
      run_text("A\nB\nC", 0,  0, 2,  640, 40,  1'b0);
      check("clipped_held", {31'b0, clipped}, {31'b0, last_clip});
      run_text("AB",      0,  0, 15, 50,  511, 1'b0);
      run_text("A B  C",  3,  7, 1,  30,  480, 1'b0);
      run_text("HELLO",   20, 30, 1, 640, 480, 1'b1);
      run_text("WORLD",   0,  0, 3,  640, 480, 1'b1);

      for (int j = 0; j < 30; j++) run_random();

      reset_mid_run();
      run_text("OK\nGO",  40, 40, 2, 640, 480, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
